seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 167 ++++++++++++++++
 tb/tb_seq_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Step sequencer with prescaler: loop, one-shot and (with SEQ_GEN_PINGPONG_EN) ping-pong modes.
// Outputs the current step both binary-encoded and one-hot; state_dbg exposes the FSM.
module seq_gen #(
   parameter int STEPS = 8,
   parameter int ENC_W = 4,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [ENC_W-1:0] len,
   input  logic [DIV_W-1:0] div,
   output logic [ENC_W-1:0] enc,
   output logic [STEPS-1:0] unenc,
   output logic             tick,
   output logic             wrap,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ENC_W-1:0] LAST_MAX = ENC_W'(STEPS - 1);

   state_t           state_q, state_d;
   logic [ENC_W-1:0] pos_q, pos_d;
   logic [STEPS-1:0] unenc_q, unenc_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             dir_q, dir_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic [DIV_W-1:0] div_q;
   logic [ENC_W-1:0] last_q;
   logic [1:0]       mode_q;
`ifdef SEQ_GEN_PINGPONG_EN
   logic             dir0_q;
   logic [ENC_W-1:0] start_pos;
`endif

   logic [ENC_W-1:0] len_clamped;
   logic [ENC_W-1:0] nxt_pos;
   logic             nxt_wrap;
   logic             nxt_dir;
   logic             one_shot_done;

   // Candidate next position, assuming an advance happens this cycle.
   always_comb begin
      nxt_pos       = pos_q;
      nxt_wrap      = 1'b0;
      nxt_dir       = dir_q;
      one_shot_done = 1'b0;
`ifdef SEQ_GEN_PINGPONG_EN
      start_pos     = dir0_q ? last_q : '0;
`endif
      if (last_q == '0) begin
         nxt_pos  = '0;
         nxt_wrap = 1'b1;
`ifdef SEQ_GEN_PINGPONG_EN
      end else if (mode_q == 2'b10) begin
         if (!dir_q) begin
            if (pos_q == last_q) begin
               nxt_pos = pos_q - ENC_W'(1);
               nxt_dir = 1'b1;
            end else begin
               nxt_pos = pos_q + ENC_W'(1);
            end
         end else begin
            if (pos_q == '0) begin
               nxt_pos = ENC_W'(1);
               nxt_dir = 1'b0;
            end else begin
               nxt_pos = pos_q - ENC_W'(1);
            end
         end
         nxt_wrap = (nxt_pos == start_pos);
`endif
      end else if (!dir_q) begin
         nxt_pos  = (pos_q == last_q) ? '0 : pos_q + ENC_W'(1);
         nxt_wrap = (pos_q == last_q);
      end else begin
         nxt_pos  = (pos_q == '0) ? last_q : pos_q - ENC_W'(1);
         nxt_wrap = (pos_q == '0);
      end
      if (mode_q == 2'b01) begin
         one_shot_done = (nxt_pos == (dir_q ? '0 : last_q));
         nxt_wrap      = one_shot_done;
      end
   end

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      presc_d     = presc_q;
      dir_d       = dir_q;
      tick_d      = 1'b0;
      wrap_d      = 1'b0;
      len_clamped = (len > LAST_MAX) ? LAST_MAX : len;
      if (start) begin
         state_d = S_RUN;
         pos_d   = dir ? len_clamped : '0;
         presc_d = '0;
         dir_d   = dir;
      end else if (state_q == S_RUN && en) begin
         if (presc_q == div_q) begin
            presc_d = '0;
            pos_d   = nxt_pos;
            dir_d   = nxt_dir;
            tick_d  = 1'b1;
            wrap_d  = nxt_wrap;
            if (one_shot_done) state_d = S_DONE;
         end else begin
            presc_d = presc_q + DIV_W'(1);
         end
      end
      unenc_d = STEPS'(1) << pos_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pos_q   <= '0;
         unenc_q <= STEPS'(1);
         presc_q <= '0;
         dir_q   <= 1'b0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         div_q   <= '0;
         last_q  <= '0;
         mode_q  <= '0;
`ifdef SEQ_GEN_PINGPONG_EN
         dir0_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         unenc_q <= unenc_d;
         presc_q <= presc_d;
         dir_q   <= dir_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
         // Configuration is captured only by the start strobe.
         if (start) begin
            div_q  <= div;
            last_q <= len_clamped;
            mode_q <= mode;
`ifdef SEQ_GEN_PINGPONG_EN
            dir0_q <= dir;
`endif
         end
      end
   end

   assign enc       = pos_q;
   assign unenc     = unenc_q;
   assign tick      = tick_q;
   assign wrap      = wrap_q;
   assign busy      = (state_q == S_RUN);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen (STEPS=8, ENC_W=4, DIV_W=16).
module tb_seq_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic        start;
   logic        dir;
   logic [1:0]  mode;
   logic [3:0]  len;
   logic [15:0] div;
   logic [3:0]  enc;
   logic [7:0]  unenc;
   logic        tick;
   logic        wrap;
   logic        busy;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   seq_gen #(.STEPS(8), .ENC_W(4), .DIV_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .start     (start),
      .dir       (dir),
      .mode      (mode),
      .len       (len),
      .div       (div),
      .enc       (enc),
      .unenc     (unenc),
      .tick      (tick),
      .wrap      (wrap),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   logic [3:0] exp_e;
`ifdef SEQ_GEN_PINGPONG_EN
   int exp_seq[7] = '{1, 2, 3, 2, 1, 0, 1};
`else
   int exp_seq[7] = '{1, 2, 3, 0, 1, 2, 3};
`endif

   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b0; dir = 1'b0;
      mode = 2'b00; len = 4'd0; div = 16'd0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_enc",   enc, 0);
      chk("rst_unenc", unenc, 8'h01);
      chk("rst_busy",  busy, 0);
      chk("rst_tick",  tick, 0);
      chk("rst_wrap",  wrap, 0);
      chk("rst_state", state_dbg, ST_IDLE);

      // loop up, len=7, div=2: advance every 3 cycles, wrap on 7->0
      mode = 2'b00; dir = 1'b0; len = 4'd7; div = 16'd2; en = 1'b1;
      pulse_start();
      chk("t1_enc0", enc, 0);
      chk("t1_busy", busy, 1);
      chk("t1_tick0", tick, 0);
      for (int k = 1; k <= 8; k++) begin
         for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c < 3) begin
               chk("t1_hold_tick", tick, 0);
            end else begin
               exp_e = 4'(k % 8);
               chk("t1_enc",   enc, exp_e);
               chk("t1_tick",  tick, 1);
               chk("t1_wrap",  wrap, (k == 8) ? 1 : 0);
               chk("t1_unenc", unenc, 32'd1 << exp_e);
            end
         end
      end

      // one-shot down, len=3, div=0: 3,2,1,0 then DONE
      mode = 2'b01; dir = 1'b1; len = 4'd3; div = 16'd0;
      pulse_start();
      chk("t2_enc0", enc, 3);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t2_enc",  enc, 2 - i);
         chk("t2_tick", tick, 1);
         chk("t2_wrap", wrap, (i == 2) ? 1 : 0);
         chk("t2_busy", busy, (i == 2) ? 0 : 1);
      end
      chk("t2_state", state_dbg, ST_DONE);
      en = 1'b0; dir = 1'b0; mode = 2'b00; len = 4'd7; div = 16'd5;
      cyc();
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t2_done_enc",   enc, 0);
         chk("t2_done_tick",  tick, 0);
         chk("t2_done_state", state_dbg, ST_DONE);
      end

      // mode 10: ping-pong when the macro is defined, loop otherwise
      mode = 2'b10; dir = 1'b0; len = 4'd3; div = 16'd0;
      pulse_start();
      chk("t3_enc0", enc, 0);
      for (int i = 0; i < 7; i++) begin
         cyc();
         chk("t3_enc",  enc, exp_seq[i]);
         chk("t3_tick", tick, 1);
         chk("t3_wrap", wrap, (exp_seq[i] == 0) ? 1 : 0);
      end

      // en low for 5 cycles mid-step at enc=4
      mode = 2'b00; dir = 1'b0; len = 4'd7; div = 16'd2;
      pulse_start();
      repeat (12) cyc();
      chk("t4_enc4", enc, 4);
      cyc();
      chk("t4_mid_enc", enc, 4);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t4_pause_enc",  enc, 4);
         chk("t4_pause_tick", tick, 0);
         chk("t4_pause_busy", busy, 1);
      end
      en = 1'b1;
      cyc();
      chk("t4_res_enc",  enc, 4);
      chk("t4_res_tick", tick, 0);
      cyc();
      chk("t4_adv_enc",  enc, 5);
      chk("t4_adv_tick", tick, 1);

      // asynchronous reset at enc=5, start ignored while rst is high
      rst = 1'b1;
      #1;
      chk("t5_rst_enc",   enc, 0);
      chk("t5_rst_unenc", unenc, 8'h01);
      chk("t5_rst_busy",  busy, 0);
      chk("t5_rst_tick",  tick, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      #2;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t5_post_enc",   enc, 0);
         chk("t5_post_tick",  tick, 0);
         chk("t5_post_wrap",  wrap, 0);
         chk("t5_post_state", state_dbg, ST_IDLE);
      end

      // len=12 clamps last to 7; down start position is 7
      mode = 2'b00; dir = 1'b1; len = 4'd12; div = 16'd0;
      pulse_start();
      chk("t6_enc",   enc, 7);
      chk("t6_unenc", unenc, 8'h80);
      cyc();
      chk("t6_enc_dn",  enc, 6);
      chk("t6_tick_dn", tick, 1);
      chk("t6_wrap_dn", wrap, 0);

      // start outranks the same-cycle advance
      dir = 1'b0; len = 4'd7;
      pulse_start();
      chk("t7_enc",  enc, 0);
      chk("t7_tick", tick, 0);

      // last=0: loop holds 0 with tick+wrap every advance
      len = 4'd0;
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("t8_enc",   enc, 0);
         chk("t8_unenc", unenc, 8'h01);
         chk("t8_tick",  tick, 1);
         chk("t8_wrap",  wrap, 1);
      end

      // last=0 one-shot: DONE on first advance
      mode = 2'b01;
      pulse_start();
      cyc();
      chk("t9_tick",  tick, 1);
      chk("t9_wrap",  wrap, 1);
      chk("t9_state", state_dbg, ST_DONE);
      chk("t9_busy",  busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
